asteroid_director: RTL and testbench
====================================

ASTEROID_DIRECTOR -- requirements
Module: asteroid_director

Interface
REQ-001 Parameters SHALL be: MOVE_DIV, 2, frames per move tick (>=1); RESPAWN_FRAMES, 60, frames between break and unbreak; SCREEN_BOTTOM, 470, asteroid y at/over which END_SCREEN is declared; X_MIN, 20, lowest spawn x; X_MAX, 619, highest spawn x; LIVES_INIT, 3, lives after reset/restart.
REQ-002 Ports SHALL be: clk in 1 clock; rst in 1 reset; pixpulse in 1 pixel enable; hcount in 10 pixel column; vcount in 10 pixel row; draw_ast in 1 asteroid pixel; draw_bullet in 1 bullet pixel; draw_ship in 1 ship pixel; ast_yloc in 10 asteroid centre y; broken in 1 asteroid broken flag; start in 1 restart request; move out 1 move tick; unbreak out 1 respawn request; break_conditions out 2 event code; bullet_hit out 1 bullet consumed; spawn_x out 10 respawn x; score out 8; lives out 2; game_over out 1.
REQ-003 Reset rst SHALL be asynchronous, active-high; clock clk.

Function
REQ-004 All state SHALL change only on clk edges with pixpulse=1, except the LFSR (every clk).
REQ-005 Eval point SHALL be the pixpulse cycle with hcount=0, vcount=480 (vblank start); all per-frame decisions occur there.
REQ-006 Each pixpulse with draw_ast&draw_bullet SHALL set hit_b; draw_ast&draw_ship SHALL set hit_s; both cleared at eval after use.
REQ-007 break_conditions codes SHALL be 00 END_SCREEN, 01 HIT_BULLET, 10 HIT_SHIP, 11 NONE; held from eval until changed by the FSM.
REQ-008 Classification priority at eval SHALL be hit_s > hit_b > (ast_yloc >= SCREEN_BOTTOM); simultaneous ship+bullet yields HIT_SHIP, no score.
REQ-009 FSM states SHALL be PLAY, RESPAWN, GAME_OVER.
REQ-010 PLAY: frame counter increments per eval; move SHALL be high for exactly one pixpulse period starting at the eval where counter reaches MOVE_DIV-1 (counter then wraps to 0).
REQ-011 PLAY, eval with event: load break_conditions, load timer with RESPAWN_FRAMES, go RESPAWN; move is also asserted that eval so the asteroid samples the code.
REQ-012 HIT_BULLET SHALL increment score saturating at 255 and pulse bullet_hit one pixpulse period.
REQ-013 HIT_SHIP SHALL decrement lives; if lives was 1, go GAME_OVER instead of RESPAWN; lives never wraps below 0.
REQ-014 END_SCREEN SHALL change neither score nor lives.
REQ-015 RESPAWN: timer decrements per eval; no move; at timer=0, latch spawn_x, assert unbreak and hold it until broken=0 is sampled on pixpulse, then deassert unbreak, set break_conditions=11, return to PLAY with frame counter 0.
REQ-016 GAME_OVER: game_over=1, move=0, unbreak=0; start=1 on pixpulse SHALL set score=0, lives=LIVES_INIT, break_conditions=11, issue the REQ-015 unbreak handshake, then PLAY. start is ignored outside GAME_OVER.
REQ-017 LFSR SHALL be 10-bit Fibonacci, taps x^10+x^7+1, seed 10'h001; spawn_candidate updates only when LFSR value is within [X_MIN, X_MAX].

Reset
REQ-018 Reset values SHALL be: state PLAY, move 0, unbreak 0, bullet_hit 0, break_conditions 11, spawn_x X_MIN, score 0, lives LIVES_INIT, game_over 0, counters/timer 0, hit flags 0, LFSR 10'h001.
REQ-019 Reset asserted mid-handshake or mid-frame SHALL abort immediately to reset values; first eval after release is treated normally.

Configuration
REQ-020 With ASTEROID_SPEEDUP_EN defined, effective move divisor SHALL be max(1, MOVE_DIV - score[7:3]); without it, divisor is MOVE_DIV fixed.

Verification
REQ-021 Bullet overlaps asteroid 3 pixels in frame N -> eval N: break_conditions=01, score 0->1, bullet_hit one pixpulse, state RESPAWN.
REQ-022 Ship and bullet both overlap in one frame, lives=3 -> break_conditions=10, lives=2, score unchanged.
REQ-023 lives=1, ship hit -> lives=0, game_over=1, no move for 5 frames; start pulse -> score 0, lives 3, unbreak until broken=0, then PLAY.
REQ-024 RESPAWN_FRAMES=60, END_SCREEN at eval N -> unbreak rises at eval N+60; broken held 1 for 4 more pixpulses -> unbreak stays high exactly until broken=0 sampled; spawn_x within [20,619].
REQ-025 MOVE_DIV=2, no events, 6 frames -> exactly 3 move pulses, each one pixpulse wide; with ASTEROID_SPEEDUP_EN and score=8 -> move every frame.
REQ-026 score=255 plus bullet hit -> score stays 255; rst asserted during unbreak -> all outputs at REQ-018 values next clk.

Source files
------------

// File: rtl/asteroid_director.sv
// Asteroid game director: per-frame collision classification, scoring, lives, respawn handshake.
// Optional macro ASTEROID_SPEEDUP_EN shortens the move divisor as score grows.
module asteroid_director #(
    parameter int MOVE_DIV       = 2,
    parameter int RESPAWN_FRAMES = 60,
    parameter int SCREEN_BOTTOM  = 470,
    parameter int X_MIN          = 20,
    parameter int X_MAX          = 619,
    parameter int LIVES_INIT     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixpulse,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       draw_ast,
    input  logic       draw_bullet,
    input  logic       draw_ship,
    input  logic [9:0] ast_yloc,
    input  logic       broken,
    input  logic       start,
    output logic       move,
    output logic       unbreak,
    output logic [1:0] break_conditions,
    output logic       bullet_hit,
    output logic [9:0] spawn_x,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over
);

    typedef enum logic [1:0] {PLAY = 2'b00, RESPAWN = 2'b01, GAME_OVER = 2'b10} state_t;

    localparam logic [1:0]  BC_END     = 2'b00;
    localparam logic [1:0]  BC_BULLET  = 2'b01;
    localparam logic [1:0]  BC_SHIP    = 2'b10;
    localparam logic [1:0]  BC_NONE    = 2'b11;
    localparam logic [15:0] MOVE_DIV_W = 16'(MOVE_DIV);
    localparam logic [15:0] RESPAWN_W  = 16'(RESPAWN_FRAMES);
    localparam logic [9:0]  BOTTOM_W   = 10'(SCREEN_BOTTOM);
    localparam logic [9:0]  X_MIN_W    = 10'(X_MIN);
    localparam logic [9:0]  X_MAX_W    = 10'(X_MAX);
    localparam logic [1:0]  LIVES_W    = 2'(LIVES_INIT);

    state_t      state_r, state_s;
    logic [15:0] frame_cnt_r, frame_cnt_s, timer_r, timer_s, div_s;
    logic        hit_b_r, hit_b_s, hit_s_r, hit_s_s;
    logic        move_r, move_s, unbreak_r, unbreak_s, bullet_hit_r, bullet_hit_s;
    logic        game_over_r, game_over_s;
    logic [1:0]  bc_r, bc_s, lives_r, lives_s;
    logic [9:0]  spawn_x_r, spawn_x_s, cand_r, cand_s, lfsr_r;
    logic [7:0]  score_r, score_s;
    logic        eval_s;

    assign eval_s = pixpulse && (hcount == 10'd0) && (vcount == 10'd480);

    // Effective move divisor, optionally shrinking with score.
`ifdef ASTEROID_SPEEDUP_EN
    logic [15:0] speed_s;
    always_comb begin
        speed_s = {11'd0, score_r[7:3]};
        if (MOVE_DIV_W > speed_s) begin
            div_s = MOVE_DIV_W - speed_s;
        end else begin
            div_s = 16'd1;
        end
    end
`else
    always_comb begin
        if (MOVE_DIV_W == 16'd0) begin
            div_s = 16'd1;
        end else begin
            div_s = MOVE_DIV_W;
        end
    end
`endif

    // Free-running spawn LFSR, x^10 + x^7 + 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= 10'h001;
        end else begin
            lfsr_r <= {lfsr_r[8:0], lfsr_r[9] ^ lfsr_r[6]};
        end
    end

    // Next-state and output decode; everything holds unless pixpulse is high.
    always_comb begin
        state_s      = state_r;
        frame_cnt_s  = frame_cnt_r;
        timer_s      = timer_r;
        hit_b_s      = hit_b_r;
        hit_s_s      = hit_s_r;
        move_s       = move_r;
        unbreak_s    = unbreak_r;
        bullet_hit_s = bullet_hit_r;
        game_over_s  = game_over_r;
        bc_s         = bc_r;
        lives_s      = lives_r;
        spawn_x_s    = spawn_x_r;
        cand_s       = cand_r;
        score_s      = score_r;
        if (pixpulse) begin
            move_s       = 1'b0;
            bullet_hit_s = 1'b0;
            if ((lfsr_r >= X_MIN_W) && (lfsr_r <= X_MAX_W)) begin
                cand_s = lfsr_r;
            end else begin
                cand_s = cand_r;
            end
            if (eval_s) begin
                hit_b_s = 1'b0;
                hit_s_s = 1'b0;
            end else begin
                hit_b_s = hit_b_r | (draw_ast & draw_bullet);
                hit_s_s = hit_s_r | (draw_ast & draw_ship);
            end
            case (state_r)
                PLAY: begin
                    if (eval_s && (hit_s_r || hit_b_r || (ast_yloc >= BOTTOM_W))) begin
                        // Move also fires here so the asteroid samples the new code.
                        move_s      = 1'b1;
                        timer_s     = RESPAWN_W;
                        frame_cnt_s = 16'd0;
                        state_s     = RESPAWN;
                        if (hit_s_r) begin
                            bc_s = BC_SHIP;
                            if (lives_r <= 2'd1) begin
                                lives_s     = 2'd0;
                                state_s     = GAME_OVER;
                                game_over_s = 1'b1;
                            end else begin
                                lives_s = lives_r - 2'd1;
                            end
                        end else if (hit_b_r) begin
                            bc_s         = BC_BULLET;
                            bullet_hit_s = 1'b1;
                            if (score_r == 8'd255) begin
                                score_s = score_r;
                            end else begin
                                score_s = score_r + 8'd1;
                            end
                        end else begin
                            bc_s = BC_END;
                        end
                    end else if (eval_s) begin
                        if (frame_cnt_r >= (div_s - 16'd1)) begin
                            frame_cnt_s = 16'd0;
                            move_s      = 1'b1;
                        end else begin
                            frame_cnt_s = frame_cnt_r + 16'd1;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                RESPAWN: begin
                    if (unbreak_r) begin
                        if (!broken) begin
                            unbreak_s   = 1'b0;
                            bc_s        = BC_NONE;
                            frame_cnt_s = 16'd0;
                            state_s     = PLAY;
                        end else begin
                            unbreak_s = 1'b1;
                        end
                    end else if (eval_s) begin
                        if (timer_r <= 16'd1) begin
                            timer_s   = 16'd0;
                            unbreak_s = 1'b1;
                            spawn_x_s = cand_r;
                        end else begin
                            timer_s = timer_r - 16'd1;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                GAME_OVER: begin
                    // Restart reuses the respawn handshake with an expired timer.
                    if (start) begin
                        score_s     = 8'd0;
                        lives_s     = LIVES_W;
                        bc_s        = BC_NONE;
                        unbreak_s   = 1'b1;
                        spawn_x_s   = cand_r;
                        timer_s     = 16'd0;
                        game_over_s = 1'b0;
                        state_s     = RESPAWN;
                    end else begin
                        state_s = state_r;
                    end
                end
                default: begin
                    state_s = PLAY;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= PLAY;
            frame_cnt_r  <= 16'd0;
            timer_r      <= 16'd0;
            hit_b_r      <= 1'b0;
            hit_s_r      <= 1'b0;
            move_r       <= 1'b0;
            unbreak_r    <= 1'b0;
            bullet_hit_r <= 1'b0;
            game_over_r  <= 1'b0;
            bc_r         <= BC_NONE;
            lives_r      <= LIVES_W;
            spawn_x_r    <= X_MIN_W;
            cand_r       <= X_MIN_W;
            score_r      <= 8'd0;
        end else begin
            state_r      <= state_s;
            frame_cnt_r  <= frame_cnt_s;
            timer_r      <= timer_s;
            hit_b_r      <= hit_b_s;
            hit_s_r      <= hit_s_s;
            move_r       <= move_s;
            unbreak_r    <= unbreak_s;
            bullet_hit_r <= bullet_hit_s;
            game_over_r  <= game_over_s;
            bc_r         <= bc_s;
            lives_r      <= lives_s;
            spawn_x_r    <= spawn_x_s;
            cand_r       <= cand_s;
            score_r      <= score_s;
        end
    end

    assign move             = move_r;
    assign unbreak          = unbreak_r;
    assign break_conditions = bc_r;
    assign bullet_hit       = bullet_hit_r;
    assign spawn_x          = spawn_x_r;
    assign score            = score_r;
    assign lives            = lives_r;
    assign game_over        = game_over_r;

endmodule

// File: tb/tb_asteroid_director.sv
// Directed bench for asteroid_director: expected values queued at stimulus time, popped at sampling.
module tb_asteroid_director;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pixpulse = 1'b0;
    logic [9:0] hcount = 10'd0;
    logic [9:0] vcount = 10'd0;
    logic       draw_ast = 1'b0;
    logic       draw_bullet = 1'b0;
    logic       draw_ship = 1'b0;
    logic [9:0] ast_yloc = 10'd100;
    logic       broken = 1'b0;
    logic       start = 1'b0;
    logic       move, unbreak, bullet_hit, game_over;
    logic [1:0] break_conditions, lives;
    logic [9:0] spawn_x;
    logic [7:0] score;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cnt_m    = 0;
    int   score_m  = 0;
    int   lives_m  = 3;

    asteroid_director dut (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
        .draw_ast(draw_ast), .draw_bullet(draw_bullet), .draw_ship(draw_ship),
        .ast_yloc(ast_yloc), .broken(broken), .start(start), .move(move),
        .unbreak(unbreak), .break_conditions(break_conditions), .bullet_hit(bullet_hit),
        .spawn_x(spawn_x), .score(score), .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic int exp_div();
`ifdef ASTEROID_SPEEDUP_EN
        int s = score_m / 8;
        return (2 > s) ? (2 - s) : 1;
`else
        return 2;
`endif
    endfunction

    // One idle clock, then one pixpulse clock; outputs are sampled 1ns after the pixpulse edge.
    task automatic pp(input logic [9:0] hc, input logic [9:0] vc,
                      input logic da, input logic db, input logic ds);
        @(posedge clk); #1;
        hcount = hc; vcount = vc;
        draw_ast = da; draw_bullet = db; draw_ship = ds;
        pixpulse = 1'b1;
        @(posedge clk); #1;
        pixpulse = 1'b0;
        draw_ast = 1'b0; draw_bullet = 1'b0; draw_ship = 1'b0;
    endtask

    task automatic check_reset_values();
        push("rst_move", 32'd0);        check(32'(move));
        push("rst_unbreak", 32'd0);     check(32'(unbreak));
        push("rst_bullet_hit", 32'd0);  check(32'(bullet_hit));
        push("rst_break_cond", 32'd3);  check(32'(break_conditions));
        push("rst_spawn_x", 32'd20);    check(32'(spawn_x));
        push("rst_score", 32'd0);       check(32'(score));
        push("rst_lives", 32'd3);       check(32'(lives));
        push("rst_game_over", 32'd0);   check(32'(game_over));
    endtask

    task automatic play_frame();
        pp(10'd150, 10'd150, 1'b0, 1'b0, 1'b0);
        push("move_low_midframe", 32'd0);
        check(32'(move));
        if (cnt_m >= exp_div() - 1) begin
            push("move_tick", 32'd1);
            cnt_m = 0;
        end else begin
            push("move_tick", 32'd0);
            cnt_m++;
        end
        pp(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
        check(32'(move));
    endtask

    // Overlap frame followed by the eval that classifies it.
    task automatic hit_frame(input logic da, input logic db, input logic ds,
                             input logic [9:0] yloc, output logic go);
        int bc;
        int bh;
        go = 1'b0;
        bh = 0;
        if (da && ds) begin
            bc = 2;
            lives_m = (lives_m <= 1) ? 0 : lives_m - 1;
            go = (lives_m == 0);
        end else if (da && db) begin
            bc = 1;
            bh = 1;
            score_m = (score_m == 255) ? 255 : score_m + 1;
        end else begin
            bc = 0;
        end
        for (int i = 0; i < 3; i++) pp(10'd200 + 10'(i), 10'd200, da, db, ds);
        push("ev_break_cond", 32'(bc));
        push("ev_score", 32'(score_m));
        push("ev_lives", 32'(lives_m));
        push("ev_bullet_hit", 32'(bh));
        push("ev_move", 32'd1);
        push("ev_game_over", 32'(go));
        ast_yloc = yloc;
        pp(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
        ast_yloc = 10'd100;
        check(32'(break_conditions));
        check(32'(score));
        check(32'(lives));
        check(32'(bullet_hit));
        check(32'(move));
        check(32'(game_over));
        push("ev_bullet_hit_width", 32'd0);
        push("ev_move_width", 32'd0);
        pp(10'd210, 10'd210, 1'b0, 1'b0, 1'b0);
        check(32'(bullet_hit));
        check(32'(move));
    endtask

    // 59 quiet evals, unbreak on the 60th, broken held for 'hold' pixpulses, then released.
    task automatic respawn_wait(input int hold);
        int quiet;
        quiet = 0;
        broken = 1'b1;
        push("respawn_quiet", 32'd0);
        for (int i = 1; i < 60; i++) begin
            pp(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
            quiet += int'(move) + int'(unbreak);
        end
        check(32'(quiet));
        push("unbreak_rise", 32'd1);
        push("spawn_x_range", 32'd1);
        pp(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
        check(32'(unbreak));
        check(32'((spawn_x >= 10'd20) && (spawn_x <= 10'd619)));
        for (int i = 0; i < hold; i++) begin
            push("unbreak_hold", 32'd1);
            pp(10'd300, 10'd300, 1'b0, 1'b0, 1'b0);
            check(32'(unbreak));
        end
        broken = 1'b0;
        push("unbreak_fall", 32'd0);
        push("break_cond_none", 32'd3);
        pp(10'd300, 10'd300, 1'b0, 1'b0, 1'b0);
        check(32'(unbreak));
        check(32'(break_conditions));
        cnt_m = 0;
    endtask

    initial begin
        logic go;
        int   quiet;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;

        // Plain frames: one move every second frame, one pixpulse wide; start ignored in PLAY.
        start = 1'b1;
        for (int f = 0; f < 6; f++) play_frame();
        start = 1'b0;
        push("start_ignored_score", 32'd0);  check(32'(score));
        push("start_ignored_lives", 32'd3);  check(32'(lives));

        // Bullet hit.
        hit_frame(1'b1, 1'b1, 1'b0, 10'd100, go);
        respawn_wait(0);

        // Just above the bottom line is no event; at the line is END_SCREEN.
        play_frame();
        ast_yloc = 10'd469;
        play_frame();
        hit_frame(1'b0, 1'b0, 1'b0, 10'd470, go);
        respawn_wait(4);

        // Ship and bullet together: ship wins, no score.
        hit_frame(1'b1, 1'b1, 1'b1, 10'd100, go);
        respawn_wait(1);
        hit_frame(1'b1, 1'b0, 1'b1, 10'd100, go);
        respawn_wait(0);
        hit_frame(1'b1, 1'b0, 1'b1, 10'd100, go);
        push("game_over_entered", 32'd1);
        check(32'(go));

        // Game over: nothing moves for 5 frames.
        for (int f = 0; f < 5; f++) begin
            quiet = 0;
            pp(10'd150, 10'd150, 1'b0, 1'b0, 1'b0);
            quiet += int'(move) + int'(unbreak);
            pp(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
            quiet += int'(move) + int'(unbreak);
            push("go_quiet", 32'd0);     check(32'(quiet));
            push("go_flag", 32'd1);      check(32'(game_over));
        end

        // Restart.
        broken = 1'b1;
        start = 1'b1;
        score_m = 0;
        lives_m = 3;
        push("restart_score", 32'd0);
        push("restart_lives", 32'd3);
        push("restart_break_cond", 32'd3);
        push("restart_unbreak", 32'd1);
        push("restart_game_over", 32'd0);
        pp(10'd150, 10'd150, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        check(32'(score));
        check(32'(lives));
        check(32'(break_conditions));
        check(32'(unbreak));
        check(32'(game_over));
        for (int i = 0; i < 2; i++) begin
            push("restart_unbreak_hold", 32'd1);
            pp(10'd160, 10'd150, 1'b0, 1'b0, 1'b0);
            check(32'(unbreak));
        end
        broken = 1'b0;
        push("restart_unbreak_fall", 32'd0);
        pp(10'd170, 10'd150, 1'b0, 1'b0, 1'b0);
        check(32'(unbreak));
        cnt_m = 0;
        for (int f = 0; f < 2; f++) play_frame();

        // Raise score to 8 and observe move cadence.
        for (int h = 0; h < 8; h++) begin
            hit_frame(1'b1, 1'b1, 1'b0, 10'd100, go);
            respawn_wait(0);
        end
        for (int f = 0; f < 4; f++) play_frame();

        // Saturate the score.
        while (score_m < 255) begin
            hit_frame(1'b1, 1'b1, 1'b0, 10'd100, go);
            respawn_wait(0);
        end
        hit_frame(1'b1, 1'b1, 1'b0, 10'd100, go);

        // Reset in the middle of the unbreak handshake.
        broken = 1'b1;
        for (int i = 0; i < 60; i++) pp(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
        push("pre_reset_unbreak", 32'd1);
        check(32'(unbreak));
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values();
        rst = 1'b0;
        broken = 1'b0;
        score_m = 0;
        lives_m = 3;
        cnt_m = 0;
        for (int f = 0; f < 3; f++) play_frame();
        push("post_reset_score", 32'd0);
        check(32'(score));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
